// File: rtl/csam_div_pkg.sv
// ----------------------------------------------------------------------------
// csam_div_pkg
// Shared definitions for the sequential signed divider that inverts the
// 16x12 signed carry-save array multiplier.
//   AW_DEF : quotient width (multiplier A operand width)
//   BW_DEF : divisor / remainder width (multiplier B operand width)
//   PW_DEF : dividend width (multiplier product width)
//   state_t: controller states
// ----------------------------------------------------------------------------
package csam_div_pkg;

    localparam int AW_DEF = 16;
    localparam int BW_DEF = 12;
    localparam int PW_DEF = AW_DEF + BW_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage : csam_div_pkg

// File: rtl/csam_div_step.sv
// ----------------------------------------------------------------------------
// csam_div_step
// One combinational restoring-division step on magnitudes.
//   rem_i  : partial remainder before the step (BW+1 bits, always < dmag_i)
//   bit_i  : next dividend bit, shifted in at the LSB
//   dmag_i : divisor magnitude (1 .. 2^(BW-1))
//   rem_o  : partial remainder after the step
//   q_o    : quotient bit produced by this step
// ----------------------------------------------------------------------------
module csam_div_step #(
    parameter int BW = 12
) (
    input  logic [BW:0]   rem_i,
    input  logic          bit_i,
    input  logic [BW-1:0] dmag_i,
    output logic [BW:0]   rem_o,
    output logic          q_o
);

    // The shifted remainder is below 2*dmag <= 2^BW and dmag <= 2^(BW-1), so
    // the trial difference lies in (-2^(BW-1), 2^BW); BW+2 bits hold it with
    // a trustworthy sign bit, even for the most negative divisor.
    logic [BW+1:0] diff_s;

    // Trial subtraction of the divisor magnitude from the shifted remainder.
    always_comb begin
        diff_s = {rem_i, bit_i} - {2'b00, dmag_i};
    end

    // Keep the difference when non-negative, otherwise restore the shifted value.
    always_comb begin
        if (diff_s[BW+1] == 1'b0) begin
            rem_o = diff_s[BW:0];
            q_o   = 1'b1;
        end else begin
            rem_o = {rem_i[BW-1:0], bit_i};
            q_o   = 1'b0;
        end
    end

endmodule : csam_div_step

// File: rtl/csam_divider.sv
// ----------------------------------------------------------------------------
// csam_divider
// Sequential signed divider: recovers the AW-bit signed quotient and BW-bit
// signed remainder from a PW-bit signed product and the BW-bit signed
// multiplier operand. Restoring division on magnitudes, one quotient bit per
// clock, valid/ready handshakes on both sides.
//   clk, reset    : rising-edge clock, asynchronous active-high reset
//   in_valid      : dividend/divisor valid (accepted while in_ready=1)
//   in_ready      : high only in IDLE
//   dividend      : PW-bit signed dividend
//   divisor       : BW-bit signed divisor
//   out_valid     : result registers valid (DONE)
//   out_ready     : consumer accepts the result
//   quotient      : AW-bit signed quotient, truncated toward zero
//   remainder     : BW-bit signed remainder, sign follows the dividend
//   overflow      : true quotient does not fit in AW signed bits
//   div_by_zero   : divisor was zero
// ----------------------------------------------------------------------------
module csam_divider
    import csam_div_pkg::*;
#(
    parameter  int AW = AW_DEF,
    parameter  int BW = BW_DEF,
    localparam int PW = AW + BW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [PW-1:0] dividend,
    input  logic [BW-1:0] divisor,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] quotient,
    output logic [BW-1:0] remainder,
    output logic          overflow,
    output logic          div_by_zero
);

    localparam int CW = $clog2(PW);

    localparam logic [CW-1:0] CNT_LAST = CW'(PW - 1);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [PW-1:0] PW_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [BW-1:0] BW_ONE   = {{(BW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] AW_ONE   = {{(AW-1){1'b0}}, 1'b1};
    // Largest magnitude of a negative AW-bit quotient: 2^(AW-1).
    localparam logic [PW-1:0] QNEG_MAX = {{(PW-AW){1'b0}}, 1'b1, {(AW-1){1'b0}}};
    // Largest positive AW-bit quotient: 2^(AW-1)-1.
    localparam logic [PW-1:0] QPOS_MAX = QNEG_MAX - PW_ONE;

    // Controller and working registers.
    state_t          state_q, state_d;
    logic [PW-1:0]   work_q, work_d;     // dividend bits out at the top, quotient bits in at the bottom
    logic [BW:0]     prem_q, prem_d;     // partial remainder
    logic [BW-1:0]   dmag_q, dmag_d;     // divisor magnitude
    logic [CW-1:0]   count_q, count_d;
    logic            qsign_q, qsign_d;
    logic            rsign_q, rsign_d;
    logic            dbz_q, dbz_d;

    // Output registers.
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic [AW-1:0]   quot_q, quot_d;
    logic [BW-1:0]   rem_q, rem_d;
    logic            ovf_q, ovf_d;
    logic            dbz_out_q, dbz_out_d;

    // Input magnitudes and step results.
    logic [PW-1:0]   dvd_mag_s;
    logic [BW-1:0]   dvs_mag_s;
    logic [BW:0]     step_rem_s;
    logic            step_q_s;
    logic            q_ovf_s;

    // Magnitudes of the raw inputs; the most negative value maps to 2^(W-1) exactly.
    always_comb begin
        if (dividend[PW-1] == 1'b1) begin
            dvd_mag_s = ~dividend + PW_ONE;
        end else begin
            dvd_mag_s = dividend;
        end
        if (divisor[BW-1] == 1'b1) begin
            dvs_mag_s = ~divisor + BW_ONE;
        end else begin
            dvs_mag_s = divisor;
        end
    end

    csam_div_step #(
        .BW (BW)
    ) u_step (
        .rem_i  (prem_q),
        .bit_i  (work_q[PW-1]),
        .dmag_i (dmag_q),
        .rem_o  (step_rem_s),
        .q_o    (step_q_s)
    );

    // Quotient range check on the full PW-bit magnitude (negative side allows one more).
    always_comb begin
        if (qsign_q == 1'b1) begin
            q_ovf_s = (work_q > QNEG_MAX);
        end else begin
            q_ovf_s = (work_q > QPOS_MAX);
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        prem_d      = prem_q;
        dmag_d      = dmag_q;
        count_d     = count_q;
        qsign_d     = qsign_q;
        rsign_d     = rsign_q;
        dbz_d       = dbz_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        ovf_d       = ovf_q;
        dbz_out_d   = dbz_out_q;

        case (state_q)
            IDLE: begin
                if (in_valid == 1'b1) begin
                    work_d     = dvd_mag_s;
                    dmag_d     = dvs_mag_s;
                    qsign_d    = dividend[PW-1] ^ divisor[BW-1];
                    rsign_d    = dividend[PW-1];
                    prem_d     = '0;
                    count_d    = CNT_LAST;
                    in_ready_d = 1'b0;
                    if (divisor == '0) begin
                        dbz_d   = 1'b1;
                        state_d = FIX;
                    end else begin
                        dbz_d   = 1'b0;
                        state_d = RUN;
                    end
                end else begin
                    state_d = IDLE;
                end
            end

            RUN: begin
                work_d  = {work_q[PW-2:0], step_q_s};
                prem_d  = step_rem_s;
                count_d = count_q - CNT_ONE;
                if (count_q == '0) begin
                    state_d = FIX;
                end else begin
                    state_d = RUN;
                end
            end

            FIX: begin
                if (dbz_q == 1'b1) begin
                    quot_d    = '0;
                    rem_d     = '0;
                    ovf_d     = 1'b0;
                    dbz_out_d = 1'b1;
                end else begin
                    // Low AW bits of the negated magnitude equal the negation of its low AW bits.
                    if (qsign_q == 1'b1) begin
                        quot_d = ~work_q[AW-1:0] + AW_ONE;
                    end else begin
                        quot_d = work_q[AW-1:0];
                    end
                    // Final remainder is below the divisor magnitude, so it fits in BW-1 magnitude bits.
                    if (rsign_q == 1'b1) begin
                        rem_d = ~prem_q[BW-1:0] + BW_ONE;
                    end else begin
                        rem_d = prem_q[BW-1:0];
                    end
                    ovf_d     = q_ovf_s;
                    dbz_out_d = 1'b0;
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end

            DONE: begin
                if (out_ready == 1'b1) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end else begin
                    state_d = DONE;
                end
            end

            default: begin
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    // State, working and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            work_q      <= '0;
            prem_q      <= '0;
            dmag_q      <= '0;
            count_q     <= '0;
            qsign_q     <= 1'b0;
            rsign_q     <= 1'b0;
            dbz_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= '0;
            rem_q       <= '0;
            ovf_q       <= 1'b0;
            dbz_out_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            prem_q      <= prem_d;
            dmag_q      <= dmag_d;
            count_q     <= count_d;
            qsign_q     <= qsign_d;
            rsign_q     <= rsign_d;
            dbz_q       <= dbz_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            ovf_q       <= ovf_d;
            dbz_out_q   <= dbz_out_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign overflow    = ovf_q;
    assign div_by_zero = dbz_out_q;

endmodule : csam_divider

// File: tb/tb_csam_divider.sv
// ----------------------------------------------------------------------------
// tb_csam_divider
// Directed, table-driven bench for csam_divider with hand-computed results,
// a reference cross-check using native signed division, and hand-written
// handshake / reset-mid-operation sequences.
// ----------------------------------------------------------------------------
module tb_csam_divider;

    localparam int AW = 16;
    localparam int BW = 12;
    localparam int PW = 28;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] dividend;
    logic [BW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] quotient;
    logic [BW-1:0] remainder;
    logic          overflow;
    logic          div_by_zero;

    int errors;
    int checks;

    typedef struct {
        logic [PW-1:0] dvd;
        logic [BW-1:0] dvs;
        logic [AW-1:0] q;
        logic [BW-1:0] r;
        logic          ovf;
        logic          dbz;
        int            lat;
        int            hold;
    } vec_t;

    vec_t vecs[15];

    csam_divider dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one operation, scramble the inputs after acceptance, wait for the
    // result, check it, optionally stall the consumer, then release it.
    task automatic run_vec(input vec_t v, input int idx);
        int     lat;
        longint a;
        longint b;
        longint mq;
        longint mr;
        logic [AW-1:0] q_snap;
        logic [BW-1:0] r_snap;
        @(negedge clk);
        check($sformatf("v%0d in_ready_before", idx), {31'd0, in_ready}, 32'd1);
        dividend = v.dvd;
        divisor  = v.dvs;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        dividend = 28'h5555555;
        divisor  = 12'h003;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("v%0d latency", idx), lat, v.lat);
        check($sformatf("v%0d quotient", idx), {16'd0, quotient}, {16'd0, v.q});
        check($sformatf("v%0d remainder", idx), {20'd0, remainder}, {20'd0, v.r});
        check($sformatf("v%0d overflow", idx), {31'd0, overflow}, {31'd0, v.ovf});
        check($sformatf("v%0d div_by_zero", idx), {31'd0, div_by_zero}, {31'd0, v.dbz});
        if (v.dbz == 1'b0) begin
            a  = longint'($signed(v.dvd));
            b  = longint'($signed(v.dvs));
            mq = a / b;
            mr = a % b;
            check($sformatf("v%0d model_q", idx), {16'd0, quotient}, {16'd0, mq[15:0]});
            check($sformatf("v%0d model_r", idx), {20'd0, remainder}, {20'd0, mr[11:0]});
            check($sformatf("v%0d model_ovf", idx), {31'd0, overflow},
                  {31'd0, (mq > 64'sd32767 || mq < -64'sd32768)});
        end
        q_snap = quotient;
        r_snap = remainder;
        for (int i = 0; i < v.hold; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("v%0d hold%0d out_valid", idx, i), {31'd0, out_valid}, 32'd1);
            check($sformatf("v%0d hold%0d in_ready", idx, i), {31'd0, in_ready}, 32'd0);
            check($sformatf("v%0d hold%0d stable_q", idx, i), {16'd0, quotient}, {16'd0, v.q});
            check($sformatf("v%0d hold%0d stable_r", idx, i), {20'd0, remainder}, {20'd0, r_snap});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check($sformatf("v%0d release out_valid", idx), {31'd0, out_valid}, 32'd0);
        check($sformatf("v%0d release in_ready", idx), {31'd0, in_ready}, 32'd1);
        check($sformatf("v%0d q_snap", idx), {16'd0, q_snap}, {16'd0, v.q});
    endtask

    initial begin
        vec_t rv;
        errors    = 0;
        checks    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        //            dividend      divisor   quotient  rem      ovf   dbz  lat hold
        vecs[0]  = '{28'h00C28BC, 12'h0AB, 16'h1234, 12'h000, 1'b0, 1'b0, 29, 5};
        vecs[1]  = '{28'hFFFFFF9, 12'h002, 16'hFFFD, 12'hFFF, 1'b0, 1'b0, 29, 0};
        vecs[2]  = '{28'h0000007, 12'hFFE, 16'hFFFD, 12'h001, 1'b0, 1'b0, 29, 0};
        vecs[3]  = '{28'h0100000, 12'h001, 16'h0000, 12'h000, 1'b1, 1'b0, 29, 0};
        vecs[4]  = '{28'h8000000, 12'hFFF, 16'h0000, 12'h000, 1'b1, 1'b0, 29, 0};
        vecs[5]  = '{28'hFFF8000, 12'h001, 16'h8000, 12'h000, 1'b0, 1'b0, 29, 0};
        vecs[6]  = '{28'h0001234, 12'h000, 16'h0000, 12'h000, 1'b0, 1'b1, 1,  2};
        vecs[7]  = '{28'h0000064, 12'hFF9, 16'hFFF2, 12'h002, 1'b0, 1'b0, 29, 0};
        vecs[8]  = '{28'hFFFFF9C, 12'h007, 16'hFFF2, 12'hFFE, 1'b0, 1'b0, 29, 0};
        vecs[9]  = '{28'hFFFFF9C, 12'hFF9, 16'h000E, 12'hFFE, 1'b0, 1'b0, 29, 0};
        vecs[10] = '{28'h0FFFFFF, 12'h800, 16'hE001, 12'h7FF, 1'b0, 1'b0, 29, 0};
        vecs[11] = '{28'h0000005, 12'h800, 16'h0000, 12'h005, 1'b0, 1'b0, 29, 0};
        vecs[12] = '{28'h8000000, 12'h001, 16'h0000, 12'h000, 1'b1, 1'b0, 29, 0};
        vecs[13] = '{28'h0007FFF, 12'h001, 16'h7FFF, 12'h000, 1'b0, 1'b0, 29, 0};
        vecs[14] = '{28'h0008000, 12'h001, 16'h8000, 12'h000, 1'b1, 1'b0, 29, 0};

        repeat (3) @(posedge clk);
        #1;
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst out_valid", {31'd0, out_valid}, 32'd0);
        check("rst quotient", {16'd0, quotient}, 32'd0);
        check("rst remainder", {20'd0, remainder}, 32'd0);
        check("rst overflow", {31'd0, overflow}, 32'd0);
        check("rst div_by_zero", {31'd0, div_by_zero}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset asserted between edges in the middle of RUN.
        @(negedge clk);
        dividend = 28'h00C28BC;
        divisor  = 12'h0AB;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("midrst out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst quotient", {16'd0, quotient}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rv = '{28'h0000800, 12'h800, 16'hFFFF, 12'h000, 1'b0, 1'b0, 29, 0};
        run_vec(rv, 99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_csam_divider
